prbs_gen_chk: RTL and testbench

// - Parametrised PRBS generator and self-synchronising checker: next generation of the single fixed PRBS31 shifter.
// - Generator adds enable, seed load, zero-seed guard and single-bit error injection.
// - Checker adds lock FSM, error pulse/counter and loss-of-lock detection.
// - Sits behind the tt_um top: gen_bit drives an output pin; chk_in is taken from an input pin (loopback/BERT use).

---
 rtl/prbs_pkg.sv | 25 ++
 rtl/prbs_chk.sv | 147 ++++++++++++++
 rtl/prbs_gen_chk.sv | 80 ++++++++
 tb/tb_prbs_gen_chk.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs_pkg.sv
// prbs_pkg: shared definitions for the PRBS generator/checker slice.
//   chk_state_t  - checker lock state (SEARCH / LOCKED)
//   PRBS31_*     - default polynomial x^31 + x^28 + 1
//   prbs_fb()    - Fibonacci feedback bit s[width-1] ^ s[tap_b-1]
package prbs_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    localparam int PRBS31_WIDTH = 31;
    localparam int PRBS31_TAP_B = 28;

    // Widest LFSR the feedback helper accepts; callers zero-extend into it.
    localparam int PRBS_MAX_W = 64;
    localparam int PRBS_IDX_W = 6;

    function automatic logic prbs_fb(input logic [PRBS_MAX_W-1:0] s,
                                     input int                    width,
                                     input int                    tap_b);
        return s[PRBS_IDX_W'(width - 1)] ^ s[PRBS_IDX_W'(tap_b - 1)];
    endfunction

endpackage

// File: rtl/prbs_chk.sv
// prbs_chk: self-synchronising PRBS checker.
//   clk, rst_n      clock; asynchronous reset, active-high (despite the name)
//   chk_in          received serial bit
//   chk_valid       qualifies chk_in; the checker only moves on valid beats
//   clr_cnt         clears err_count (an error in the same cycle leaves 1)
//   locked          registered: checker is in LOCKED
//   err_pulse       one-cycle pulse per mismatched bit while locked
//   err_count       saturating error count
//   stuck           registered: shift register all-zero after a full fill
module prbs_chk
    import prbs_pkg::*;
#(
    parameter int WIDTH       = PRBS31_WIDTH,
    parameter int TAP_B       = PRBS31_TAP_B,
    parameter int LOCK_THRESH = 32,
    parameter int WIN_LEN     = 64,
    parameter int LOSS_THRESH = 4,
    parameter int CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             chk_in,
    input  logic             chk_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck
);

    localparam int FILL_W = $clog2(WIDTH + 1);
    localparam int GOOD_W = $clog2(LOCK_THRESH + 1);
    localparam int WIN_W  = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam int WERR_W = $clog2(LOSS_THRESH + 1);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(WIDTH);
    localparam logic [GOOD_W-1:0] GOOD_LAST = GOOD_W'(LOCK_THRESH - 1);
    localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(WIN_LEN - 1);
    localparam logic [WERR_W-1:0] LOSS_V    = WERR_W'(LOSS_THRESH);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    chk_state_t        r_state;
    logic [WIDTH-1:0]  r_c;
    logic [FILL_W-1:0] r_fill;
    logic [GOOD_W-1:0] r_good;
    logic [WIN_W-1:0]  r_win;
    logic [WERR_W-1:0] r_werr;
    logic              r_locked;
    logic              r_err_pulse;
    logic [CNT_W-1:0]  r_err_count;
    logic              r_stuck;

    logic              w_pred;
    logic              w_match;
    logic              w_c_zero;
    logic              w_full;
    logic              w_wrap;
    logic              w_err_hit;
    logic [WERR_W-1:0] w_werr_next;

    assign w_pred      = prbs_fb(PRBS_MAX_W'(r_c), WIDTH, TAP_B);
    assign w_match     = (chk_in == w_pred);
    assign w_c_zero    = (r_c == '0);
    assign w_full      = (r_fill == FILL_FULL);
    assign w_wrap      = (r_win == WIN_LAST);
    assign w_err_hit   = chk_valid && (r_state == LOCKED) && !w_match;
    assign w_werr_next = r_werr + WERR_W'(w_err_hit);

    // Lock FSM: in SEARCH the register tracks the line; in LOCKED it runs
    // free on its own prediction so a line error cannot corrupt the reference.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_state  <= SEARCH;
            r_locked <= 1'b0;
            r_c      <= '0;
            r_fill   <= '0;
            r_good   <= '0;
            r_win    <= '0;
            r_werr   <= '0;
        end else if (chk_valid) begin
            case (r_state)
                SEARCH: begin
                    r_c <= {r_c[WIDTH-2:0], chk_in};
                    if (!w_full) begin
                        r_fill <= r_fill + 1'b1;
                    end else if (w_match && !w_c_zero) begin
                        if (r_good == GOOD_LAST) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_good   <= '0;
                            r_win    <= '0;
                            r_werr   <= '0;
                        end else begin
                            r_good <= r_good + 1'b1;
                        end
                    end else begin
                        // An all-zero register trivially "matches" a zero line.
                        r_good <= '0;
                    end
                end
                LOCKED: begin
                    if (w_werr_next >= LOSS_V) begin
                        r_state  <= SEARCH;
                        r_locked <= 1'b0;
                        r_c      <= '0;
                        r_fill   <= '0;
                        r_good   <= '0;
                    end else begin
                        r_c    <= {r_c[WIDTH-2:0], w_pred};
                        r_win  <= w_wrap ? '0 : r_win + 1'b1;
                        r_werr <= w_wrap ? '0 : w_werr_next;
                    end
                end
                default: begin
                    r_state  <= SEARCH;
                    r_locked <= 1'b0;
                end
            endcase
        end
    end

    // Error reporting stage: pulse and count land one cycle after the beat.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_stuck     <= 1'b0;
        end else begin
            r_err_pulse <= w_err_hit;
            if (clr_cnt) begin
                r_err_count <= CNT_W'(w_err_hit);
            end else if (w_err_hit) begin
                r_err_count <= sat_inc(r_err_count);
            end
            r_stuck <= w_full && w_c_zero;
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign stuck     = r_stuck;

endmodule

// File: rtl/prbs_gen_chk.sv
// prbs_gen_chk: PRBS generator plus self-synchronising checker.
//   clk, rst_n      clock; asynchronous reset, active-high (despite the name)
//   en              advance the generator one step
//   load, seed      load a seed (priority over en); seed 0 loads SEED
//   inject_err      invert the bit emitted on this en cycle
//   gen_bit         registered generator output
//   chk_in          received bit, chk_valid its qualifier
//   clr_cnt         clear the error counter
//   locked, err_pulse, err_count, stuck   checker status (see prbs_chk)
module prbs_gen_chk
    import prbs_pkg::*;
#(
    parameter int               WIDTH       = PRBS31_WIDTH,
    parameter int               TAP_B       = PRBS31_TAP_B,
    parameter logic [WIDTH-1:0] SEED        = WIDTH'(1),
    parameter int               LOCK_THRESH = 32,
    parameter int               WIN_LEN     = 64,
    parameter int               LOSS_THRESH = 4,
    parameter int               CNT_W       = 16
)(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             inject_err,
    output logic             gen_bit,
    input  logic             chk_in,
    input  logic             chk_valid,
    input  logic             clr_cnt,
    output logic             locked,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_count,
    output logic             stuck
);

    logic [WIDTH-1:0] r_gen_state;
    logic             r_gen_bit;
    logic             w_gen_fb;
    logic [WIDTH-1:0] w_load_val;

    assign w_gen_fb   = prbs_fb(PRBS_MAX_W'(r_gen_state), WIDTH, TAP_B);
    // A zero seed would lock the LFSR at zero forever.
    assign w_load_val = (seed == '0) ? SEED : seed;

    // Generator stage: gen_bit is the MSB leaving the register this step.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_gen_state <= SEED;
            r_gen_bit   <= 1'b0;
        end else if (load) begin
            r_gen_state <= w_load_val;
        end else if (en) begin
            r_gen_state <= {r_gen_state[WIDTH-2:0], w_gen_fb};
            r_gen_bit   <= r_gen_state[WIDTH-1] ^ inject_err;
        end
    end

    assign gen_bit = r_gen_bit;

    prbs_chk #(
        .WIDTH       (WIDTH),
        .TAP_B       (TAP_B),
        .LOCK_THRESH (LOCK_THRESH),
        .WIN_LEN     (WIN_LEN),
        .LOSS_THRESH (LOSS_THRESH),
        .CNT_W       (CNT_W)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .chk_in    (chk_in),
        .chk_valid (chk_valid),
        .clr_cnt   (clr_cnt),
        .locked    (locked),
        .err_pulse (err_pulse),
        .err_count (err_count),
        .stuck     (stuck)
    );

endmodule

// File: tb/tb_prbs_gen_chk.sv
// tb_prbs_gen_chk: directed + randomized bench for prbs_gen_chk with a
// stream-level reference model (generator as a bit recurrence, checker as a
// history of received/predicted bits).
module tb_prbs_gen_chk;

    localparam int W    = 31;
    localparam int TB   = 28;
    localparam int LT   = 32;
    localparam int WL   = 64;
    localparam int LS   = 4;
    localparam int CW   = 4;
    localparam int CMAX = (1 << CW) - 1;
    localparam logic [W-1:0] SEED = W'(1);

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          load;
    logic [W-1:0]  seed;
    logic          inject_err;
    logic          gen_bit;
    wire           chk_in;
    logic          chk_valid;
    logic          clr_cnt;
    logic          locked;
    logic          err_pulse;
    logic [CW-1:0] err_count;
    logic          stuck;

    // Line source: loopback (optionally inverted) or a directly driven bit.
    logic lp;
    logic inv;
    logic drv;
    assign chk_in = lp ? (gen_bit ^ inv) : drv;

    prbs_gen_chk #(.CNT_W(CW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .seed       (seed),
        .inject_err (inject_err),
        .gen_bit    (gen_bit),
        .chk_in     (chk_in),
        .chk_valid  (chk_valid),
        .clr_cnt    (clr_cnt),
        .locked     (locked),
        .err_pulse  (err_pulse),
        .err_count  (err_count),
        .stuck      (stuck)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_fail = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    bit gz[$];      // upcoming generator output bits, next one at index 0
    bit m_gen_bit;
    bit mh[$];      // checker history, oldest first, W entries
    bit m_locked;
    int m_fill, m_good, m_beats, m_werr;
    bit m_pulse, m_stuck;
    int m_cnt;

    task automatic gen_load(input logic [W-1:0] v);
        gz.delete();
        for (int k = 0; k < W; k++) gz.push_back(v[W-1-k]);
    endtask

    task automatic model_reset();
        gen_load(SEED);
        m_gen_bit = 0;
        mh.delete();
        repeat (W) mh.push_back(1'b0);
        m_locked = 0; m_fill = 0; m_good = 0; m_beats = 0; m_werr = 0;
        m_pulse = 0; m_stuck = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit en_i, input bit load_i, input logic [W-1:0] seed_i,
                              input bit inj_i, input bit valid_i, input bit clr_i, input bit b);
        bit allz, pred, err, stuck_nx, nb;
        int e;
        allz = 1;
        foreach (mh[k]) if (mh[k]) allz = 0;
        stuck_nx = (m_fill == W) && allz;
        err = 0;
        if (valid_i) begin
            // Next bit = bit seen W beats ago xor bit seen TB beats ago.
            pred = mh[0] ^ mh[W-TB];
            if (!m_locked) begin
                if (m_fill < W) m_fill++;
                else if (b == pred && !allz) begin
                    if (m_good == LT-1) begin
                        m_locked = 1; m_good = 0; m_beats = 0; m_werr = 0;
                    end else m_good++;
                end else m_good = 0;
                void'(mh.pop_front());
                mh.push_back(b);
            end else begin
                err = (b != pred);
                e = m_werr + int'(err);
                if (e >= LS) begin
                    m_locked = 0; m_fill = 0; m_good = 0;
                    foreach (mh[k]) mh[k] = 1'b0;
                end else begin
                    void'(mh.pop_front());
                    mh.push_back(pred);
                    m_beats++;
                    m_werr = (m_beats % WL == 0) ? 0 : e;
                end
            end
        end
        m_pulse = err;
        if (clr_i) m_cnt = int'(err);
        else if (err && m_cnt < CMAX) m_cnt++;
        m_stuck = stuck_nx;
        if (load_i) begin
            gen_load((seed_i == '0) ? SEED : seed_i);
        end else if (en_i) begin
            nb = gz[0] ^ gz[W-TB];
            m_gen_bit = gz[0] ^ inj_i;
            void'(gz.pop_front());
            gz.push_back(nb);
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("gen_bit",   32'(gen_bit),   32'(m_gen_bit));
        chk("locked",    32'(locked),    32'(m_locked));
        chk("err_pulse", 32'(err_pulse), 32'(m_pulse));
        chk("err_count", 32'(err_count), 32'(m_cnt));
        chk("stuck",     32'(stuck),     32'(m_stuck));
    endtask

    task automatic tick(input bit en_i, input bit load_i, input logic [W-1:0] seed_i,
                        input bit inj_i, input bit valid_i, input bit clr_i);
        bit b;
        en = en_i; load = load_i; seed = seed_i; inject_err = inj_i;
        chk_valid = valid_i; clr_cnt = clr_i;
        b = lp ? (m_gen_bit ^ inv) : drv;
        model_step(en_i, load_i, seed_i, inj_i, valid_i, clr_i, b);
        @(posedge clk);
        #1;
        check_all();
    endtask

    // Reset asserted between edges: outputs must clear without a clock.
    task automatic async_reset();
        #2 rst_n = 1'b1;
        #1 model_reset();
        check_all();
        @(posedge clk); #1;
        check_all();
        @(negedge clk) rst_n = 1'b0;
    endtask

    int n_inv;

    initial begin
        rst_n = 1'b1; en = 0; load = 0; seed = '0; inject_err = 0;
        chk_valid = 0; clr_cnt = 0; lp = 0; inv = 0; drv = 0;
        model_reset();
        repeat (3) @(posedge clk);
        #1 check_all();
        @(negedge clk) rst_n = 1'b0;

        // Free-running generator from the reset seed.
        repeat (40) tick(1, 0, '0, 0, 0, 0);

        // Zero seed falls back to SEED; load wins over en and holds gen_bit.
        tick(1, 1, '0, 0, 0, 0);
        repeat (10) tick(1, 0, '0, 0, 0, 0);
        tick(1, 1, W'(5), 0, 0, 0);
        for (int i = 0; i < 100; i++)
            tick($urandom_range(0, 3) != 0, 0, '0, $urandom_range(0, 15) == 0, 0, 0);

        // Loopback acquisition from a fresh reset.
        async_reset();
        lp = 1; inv = 0;
        for (int i = 0; i < 200 && !m_locked; i++) tick(1, 0, '0, 0, 1, 0);
        chk("lock_reached", 32'(locked), 32'd1);
        repeat (5) tick(1, 0, '0, 0, 1, 0);

        // Three isolated injected errors: counted, lock kept.
        for (int i = 0; i < 3; i++) begin
            tick(1, 0, '0, 1, 1, 0);
            repeat (9) tick(1, 0, '0, 0, 1, 0);
        end
        chk("three_err_count", 32'(err_count), 32'd3);
        chk("three_err_locked", 32'(locked), 32'd1);
        repeat (70) tick(1, 0, '0, 0, 1, 0);

        // Sparse errors (at most 3 per window) drive the counter to saturation.
        for (int i = 0; i < 20; i++) begin
            tick(1, 0, '0, 1, 1, 0);
            repeat (24 + $urandom_range(0, 5)) tick(1, 0, '0, 0, 1, 0);
        end
        chk("cnt_saturated", 32'(err_count), 32'(CMAX));
        chk("sat_locked", 32'(locked), 32'd1);

        // Clear coincident with an error leaves 1; clear alone leaves 0.
        tick(1, 0, '0, 1, 1, 0);
        tick(1, 0, '0, 0, 1, 1);
        chk("clr_with_err", 32'(err_count), 32'd1);
        tick(1, 0, '0, 0, 1, 1);
        chk("clr_alone", 32'(err_count), 32'd0);
        chk("clr_keeps_lock", 32'(locked), 32'd1);

        // Random valid gating on a clean loopback keeps lock.
        for (int i = 0; i < 120; i++) begin
            bit v;
            v = $urandom_range(0, 3) != 0;
            tick(v, 0, '0, 0, v, 0);
        end
        repeat (70) tick(1, 0, '0, 0, 1, 0);

        // Inverted line: lock drops on the LS-th error of a window.
        inv = 1;
        n_inv = 0;
        for (int i = 0; i < 20 && m_locked; i++) begin
            tick(1, 0, '0, 0, 1, 0);
            n_inv++;
        end
        chk("loss_beats", 32'(n_inv), 32'(LS));
        chk("loss_unlocked", 32'(locked), 32'd0);
        repeat (40) tick(1, 0, '0, 0, 1, 0);

        // All-zero line: stuck, never locks.
        lp = 0; inv = 0; drv = 0;
        repeat (150) tick(0, 0, '0, 0, 1, 0);
        chk("zero_stuck", 32'(stuck), 32'd1);
        chk("zero_no_lock", 32'(locked), 32'd0);

        // Random line noise with random valid.
        for (int i = 0; i < 60; i++) begin
            drv = 1'($urandom_range(0, 1));
            tick(0, 0, '0, 0, $urandom_range(0, 1) == 1, 0);
        end

        async_reset();
        repeat (3) tick(0, 0, '0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
